energy_window_logger: RTL and testbench

//  Downstream data stage of the converter top (tt_um_vedm_industries).

---
 rtl/energy_window_logger.sv | 90 +++++++++
 tb/tb_energy_window_logger.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/energy_window_logger.sv
// energy_window_logger: per-window sum/min/max/avg of power samples into a FWFT record FIFO
module energy_window_logger #(
  parameter int DATA_W = 8,
  parameter int WIN_LOG2 = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int ACC_W = DATA_W + WIN_LOG2,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = $clog2(FIFO_DEPTH)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_avg,
  output logic [CW-1:0]     fifo_count,
  output logic              overflow
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state;
  logic [WIN_LOG2-1:0] cnt;
  logic [ACC_W-1:0] sum, sum_n;
  logic [DATA_W-1:0] mn, mx, mn_n, mx_n;
  logic [ACC_W-1:0] mem_sum [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_min [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_max [FIFO_DEPTH];
  logic [PW-1:0] wr, rd;
  logic last, push, pop, wr_en;
  always_comb begin
    sum_n = (state == ACCUM) ? sum + ACC_W'(in_data) : ACC_W'(in_data);
    mn_n = (state == ACCUM && mn < in_data) ? mn : in_data;
    mx_n = (state == ACCUM && mx > in_data) ? mx : in_data;
    last = state == ACCUM && &cnt;
    push = in_valid && last;
    pop = out_valid && out_ready;
    wr_en = push && (fifo_count != CW'(FIFO_DEPTH) || pop);
  end
  assign out_valid = fifo_count != '0;
  assign out_sum = mem_sum[rd];
  assign out_min = mem_min[rd];
  assign out_max = mem_max[rd];
  assign out_avg = out_sum[ACC_W-1:WIN_LOG2];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sum <= '0;
      mn <= '0;
      mx <= '0;
      wr <= '0;
      rd <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_sum[i] <= '0;
        mem_min[i] <= '0;
        mem_max[i] <= '0;
      end
    end else if (clear) begin
      state <= IDLE;
      cnt <= '0;
      wr <= '0;
      rd <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        sum <= sum_n;
        mn <= mn_n;
        mx <= mx_n;
        cnt <= cnt + 1'b1;
        state <= last ? IDLE : ACCUM;
      end
      if (wr_en) begin
        mem_sum[wr] <= sum_n;
        mem_min[wr] <= mn_n;
        mem_max[wr] <= mx_n;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
      fifo_count <= fifo_count + CW'(wr_en) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_energy_window_logger.sv
// tb_energy_window_logger: directed scenarios plus random traffic against a queue-based window/FIFO model
module tb_energy_window_logger;
  localparam int WIN = 16, DEPTH = 4;
  logic clk = 0, rst = 1, in_valid = 0, clear = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic out_valid, overflow;
  logic [11:0] out_sum;
  logic [7:0] out_min, out_max, out_avg;
  logic [2:0] fifo_count;
  int checks = 0, failures = 0;
  typedef struct {int s; int mn; int mx;} rec_t;
  rec_t q[$];
  int win[$];
  bit ovf;
  energy_window_logger dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_min(out_min),
    .out_max(out_max), .out_avg(out_avg), .fifo_count(fifo_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
    end
  endtask
  // Model: collect raw samples per window, derive the record only once the window is full
  always @(posedge clk or posedge rst) begin
    bit pop, have;
    rec_t r;
    if (rst) begin
      q.delete();
      win.delete();
      ovf = 0;
    end else if (clear) begin
      q.delete();
      win.delete();
      ovf = 0;
    end else begin
      pop = q.size() != 0 && out_ready;
      have = 0;
      if (in_valid) begin
        win.push_back(int'(in_data));
        if (win.size() == WIN) begin
          r.s = 0; r.mn = 255; r.mx = 0;
          foreach (win[i]) begin
            r.s += win[i];
            if (win[i] < r.mn) r.mn = win[i];
            if (win[i] > r.mx) r.mx = win[i];
          end
          have = 1;
          win.delete();
        end
      end
      if (pop) void'(q.pop_front());
      if (have) begin
        if (q.size() < DEPTH) q.push_back(r);
        else ovf = 1;
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    chk("valid", out_valid, q.size() != 0);
    chk("count", fifo_count, q.size());
    chk("overflow", overflow, ovf);
    if (q.size() != 0) begin
      chk("sum", out_sum, q[0].s);
      chk("min", out_min, q[0].mn);
      chk("max", out_max, q[0].mx);
      chk("avg", out_avg, q[0].s / WIN);
    end
  end
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
    @(negedge clk);
    #1 in_valid = v; in_data = d; out_ready = r; clear = c;
    @(posedge clk);
    #1 in_valid = 0; out_ready = 0; clear = 0;
  endtask
  task automatic window(input logic [7:0] d);
    repeat (WIN) step(1, d, 0, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 chk("rst_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_sum", out_sum, 0);
    rst = 0;
    repeat (15) step(1, 25, 0, 0);
    @(negedge clk) chk("t1_pre_valid", out_valid, 0);
    step(1, 25, 0, 0);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_sum", out_sum, 400);
    chk("t1_min", out_min, 25);
    chk("t1_max", out_max, 25);
    chk("t1_avg", out_avg, 25);
    step(0, 0, 1, 0);
    for (int i = 0; i < WIN; i++) begin
      step(1, 8'(i), 0, 0);
      repeat ($urandom_range(0, 2)) step(0, 0, 0, 0);
    end
    @(negedge clk);
    chk("t2_sum", out_sum, 120);
    chk("t2_min", out_min, 0);
    chk("t2_max", out_max, 15);
    chk("t2_avg", out_avg, 7);
    step(0, 0, 1, 0);
    repeat (5) window(45);
    @(negedge clk);
    chk("t3_count", fifo_count, 4);
    chk("t3_ovf", overflow, 1);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("t3_sum", out_sum, 720);
      chk("t3_avg", out_avg, 45);
      step(0, 0, 1, 0);
    end
    @(negedge clk) chk("t3_empty", out_valid, 0);
    step(0, 0, 0, 1);
    @(negedge clk) chk("t4_ovf_clr", overflow, 0);
    for (int k = 0; k < DEPTH; k++) window(8'(10 + k));
    repeat (WIN - 1) step(1, 99, 0, 0);
    step(1, 99, 1, 0);
    @(negedge clk);
    chk("t4_count", fifo_count, 4);
    chk("t4_ovf", overflow, 0);
    chk("t4_head", out_sum, 176);
    repeat (3) step(0, 0, 1, 0);
    @(negedge clk) chk("t4_tail", out_sum, 1584);
    step(0, 0, 1, 0);
    repeat (5) window(1);
    repeat (7) step(1, 3, 0, 0);
    step(1, 200, 0, 1);
    @(negedge clk);
    chk("t5_clr_valid", out_valid, 0);
    chk("t5_clr_ovf", overflow, 0);
    window(255);
    @(negedge clk);
    chk("t5_sum", out_sum, 4080);
    chk("t5_min", out_min, 255);
    chk("t5_max", out_max, 255);
    chk("t5_avg", out_avg, 255);
    step(0, 0, 1, 0);
    repeat (2) window(7);
    repeat (9) step(1, 9, 0, 0);
    @(negedge clk) chk("t6_pre_count", fifo_count, 2);
    #2 rst = 1;
    #1 chk("t6_valid", out_valid, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_sum", out_sum, 0);
    chk("t6_min", out_min, 0);
    chk("t6_max", out_max, 0);
    chk("t6_avg", out_avg, 0);
    chk("t6_ovf", overflow, 0);
    @(negedge clk) #1 rst = 0;
    window(50);
    @(negedge clk);
    chk("t6_count_after", fifo_count, 1);
    chk("t6_sum_after", out_sum, 800);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 127) == 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
